// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: config FSM states and legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        CFG_IDLE  = 2'd0,
        CFG_PEND  = 2'd1,
        CFG_APPLY = 2'd2
    } cfg_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive word buffer: power-of-two circular FIFO with show-ahead read port and occupancy count.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wr_valid_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_ready_i,
    output logic                          rd_valid_o,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop;

    assign full_o     = (count_q == DEPTH_C);
    assign rd_valid_o = (count_q != '0);
    assign pop        = rd_ready_i && rd_valid_o;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the word.
    assign push       = wr_valid_i && (!full_o || pop);
    assign rd_data_o  = rd_valid_o ? mem[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: deferred config apply FSM, receive buffer and error tracking.
// Error counters are built only when UART_RX_CTRL_ERR_CNT_EN is defined; otherwise the count ports read 0.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          cfg_wr,
    input  logic [5:0]                    cfg_prescale,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_typ,
    output logic                          cfg_busy,
    output logic                          cfg_done,
    output logic                          cfg_err,
    output logic [5:0]                    prescale,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          rx_busy,
    input  logic                          Data_Valid,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          par_err,
    input  logic                          stp_err,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovr_err,
    input  logic                          err_clr,
    output logic [7:0]                    par_err_cnt,
    output logic [7:0]                    stp_err_cnt
);
    cfg_state_e state_q;
    logic [5:0] sh_ps_q, prescale_q;
    logic       sh_pe_q, sh_pt_q, par_en_q, par_typ_q;
    logic       busy_q, done_q, err_q, ovr_q, ovr_d;
    logic       wr_legal, fifo_full;

    assign wr_legal = cfg_wr && prescale_legal(cfg_prescale);

    // The applied values change on the edge that first sees rx_busy low, so they never move mid-frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CFG_IDLE;
            sh_ps_q    <= '0;
            sh_pe_q    <= 1'b0;
            sh_pt_q    <= 1'b0;
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                CFG_IDLE: begin
                    if (wr_legal) begin
                        sh_ps_q <= cfg_prescale;
                        sh_pe_q <= cfg_par_en;
                        sh_pt_q <= cfg_par_typ;
                        state_q <= CFG_PEND;
                        busy_q  <= 1'b1;
                    end else if (cfg_wr) begin
                        err_q <= 1'b1;
                    end
                end
                CFG_PEND: begin
                    if (wr_legal) begin
                        sh_ps_q <= cfg_prescale;
                        sh_pe_q <= cfg_par_en;
                        sh_pt_q <= cfg_par_typ;
                    end else if (cfg_wr) begin
                        err_q <= 1'b1;
                    end
                    if (!rx_busy) begin
                        prescale_q <= wr_legal ? cfg_prescale : sh_ps_q;
                        par_en_q   <= wr_legal ? cfg_par_en   : sh_pe_q;
                        par_typ_q  <= wr_legal ? cfg_par_typ  : sh_pt_q;
                        done_q     <= 1'b1;
                        state_q    <= CFG_APPLY;
                    end
                end
                default: begin
                    state_q <= CFG_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_busy = busy_q;
    assign cfg_done = done_q;
    assign cfg_err  = err_q;
    assign prescale = prescale_q;
    assign PAR_EN   = par_en_q;
    assign PAR_TYP  = par_typ_q;

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .wr_valid_i (Data_Valid),
        .wr_data_i  (P_DATA),
        .rd_ready_i (rd_ready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full)
    );

    // A word is dropped only when full and nothing is popped in the same cycle.
    always_comb begin
        ovr_d = ovr_q;
        if (Data_Valid && fifo_full && !rd_ready) ovr_d = 1'b1;
        if (err_clr) ovr_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) ovr_q <= 1'b0;
        else     ovr_q <= ovr_d;
    end

    assign ovr_err = ovr_q;

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] par_cnt_q, stp_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST || err_clr) begin
            par_cnt_q <= '0;
            stp_cnt_q <= '0;
        end else begin
            if (par_err && (par_cnt_q != 8'hFF)) par_cnt_q <= par_cnt_q + 8'd1;
            if (stp_err && (stp_cnt_q != 8'hFF)) stp_cnt_q <= stp_cnt_q + 8'd1;
        end
    end

    assign par_err_cnt = par_cnt_q;
    assign stp_err_cnt = stp_cnt_q;
`else
    logic unused_err;
    assign unused_err  = par_err ^ stp_err;
    assign par_err_cnt = '0;
    assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
// Counter expectations follow UART_RX_CTRL_ERR_CNT_EN when it is defined for the build.
module tb_uart_rx_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST, cfg_wr, cfg_par_en, cfg_par_typ, rx_busy, Data_Valid;
    logic [5:0] cfg_prescale;
    logic [DW-1:0] P_DATA;
    logic       par_err, stp_err, rd_ready, err_clr;
    logic       cfg_busy, cfg_done, cfg_err, PAR_EN, PAR_TYP, rd_valid, ovr_err;
    logic [5:0] prescale;
    logic [DW-1:0] rd_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0] par_err_cnt, stp_err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit            m_pend, m_apply, m_ovr, m_done, m_err;
    int            m_sh_ps, m_ap_ps, m_pcnt, m_scnt;
    bit            m_sh_pe, m_sh_pt, m_ap_pe, m_ap_pt;
    logic [DW-1:0] m_q[$];

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
        .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .prescale(prescale), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .rx_busy(rx_busy), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
        .par_err(par_err), .stp_err(stp_err), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ready(rd_ready), .fifo_count(fifo_count), .ovr_err(ovr_err), .err_clr(err_clr),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pend = 0; m_apply = 0; m_ovr = 0; m_done = 0; m_err = 0;
        m_sh_ps = 0; m_sh_pe = 0; m_sh_pt = 0;
        m_ap_ps = 8; m_ap_pe = 0; m_ap_pt = 0;
        m_pcnt = 0; m_scnt = 0;
        m_q.delete();
    endtask

    task automatic model_update();
        bit was_pend, legal;
        if (RST) begin
            model_reset();
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (m_apply) begin
            m_apply = 0;
        end else begin
            was_pend = m_pend;
            legal = (cfg_prescale == 8) || (cfg_prescale == 16) || (cfg_prescale == 32);
            if (cfg_wr && legal) begin
                m_sh_ps = int'(cfg_prescale); m_sh_pe = cfg_par_en; m_sh_pt = cfg_par_typ;
                m_pend = 1;
            end else if (cfg_wr) begin
                m_err = 1;
            end
            if (was_pend && !rx_busy) begin
                m_ap_ps = m_sh_ps; m_ap_pe = m_sh_pe; m_ap_pt = m_sh_pt;
                m_done = 1; m_pend = 0; m_apply = 1;
            end
        end
        if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (Data_Valid) begin
            if (m_q.size() < DEPTH) m_q.push_back(P_DATA);
            else m_ovr = 1;
        end
        if (err_clr) begin
            m_ovr = 0; m_pcnt = 0; m_scnt = 0;
        end else begin
            if (par_err && m_pcnt < 255) m_pcnt++;
            if (stp_err && m_scnt < 255) m_scnt++;
        end
    endtask

    task automatic compare_all();
        chk("cfg_busy", cfg_busy, m_pend || m_apply);
        chk("cfg_done", cfg_done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("prescale", prescale, m_ap_ps);
        chk("PAR_EN", PAR_EN, m_ap_pe);
        chk("PAR_TYP", PAR_TYP, m_ap_pt);
        chk("rd_valid", rd_valid, m_q.size() > 0);
        chk("fifo_count", fifo_count, m_q.size());
        if (m_q.size() > 0) chk("rd_data", rd_data, m_q[0]);
        chk("ovr_err", ovr_err, m_ovr);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        chk("par_err_cnt", par_err_cnt, m_pcnt);
        chk("stp_err_cnt", stp_err_cnt, m_scnt);
`else
        chk("par_err_cnt", par_err_cnt, 0);
        chk("stp_err_cnt", stp_err_cnt, 0);
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic idle_inputs();
        RST = 0; cfg_wr = 0; cfg_prescale = 6'd0; cfg_par_en = 0; cfg_par_typ = 0;
        rx_busy = 0; Data_Valid = 0; P_DATA = '0; par_err = 0; stp_err = 0;
        rd_ready = 0; err_clr = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        RST = 1;
        step();
        step();
        RST = 0;
        chk("rst_prescale", prescale, 8);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", cfg_busy, 0);

        // Legal write held off by an active frame
        cfg_wr = 1; cfg_prescale = 6'd16; cfg_par_en = 1; rx_busy = 1;
        step();
        cfg_wr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_prescale", prescale, 8);
            chk("hold_busy", cfg_busy, 1);
        end
        rx_busy = 0;
        step();
        chk("apply_prescale", prescale, 16);
        chk("apply_par_en", PAR_EN, 1);
        chk("apply_done", cfg_done, 1);
        step();
        chk("apply_done_low", cfg_done, 0);
        chk("apply_busy_low", cfg_busy, 0);

        // Illegal ratio rejected
        cfg_wr = 1; cfg_prescale = 6'd12;
        step();
        cfg_wr = 0;
        chk("rej_err", cfg_err, 1);
        chk("rej_prescale", prescale, 16);
        chk("rej_busy", cfg_busy, 0);
        step();
        chk("rej_err_low", cfg_err, 0);

        // Overrun: five words into a depth-4 buffer
        for (int i = 1; i <= 5; i++) begin
            Data_Valid = 1; P_DATA = DW'(8'h11 * i);
            step();
        end
        Data_Valid = 0;
        step();
        chk("ovr_count", fifo_count, 4);
        chk("ovr_flag", ovr_err, 1);
        rd_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_read", rd_data, 8'h11 * i);
            step();
        end
        rd_ready = 0;
        chk("ovr_empty", rd_valid, 0);

        // Full buffer with simultaneous push and pop
        err_clr = 1;
        step();
        err_clr = 0;
        for (int i = 1; i <= 4; i++) begin
            Data_Valid = 1; P_DATA = DW'(8'h11 * i);
            step();
        end
        P_DATA = 8'h55; rd_ready = 1;
        step();
        Data_Valid = 0; rd_ready = 0;
        chk("full_pp_count", fifo_count, 4);
        chk("full_pp_ovr", ovr_err, 0);
        rd_ready = 1;
        for (int i = 2; i <= 5; i++) begin
            chk("full_pp_read", rd_data, 8'h11 * i);
            step();
        end
        rd_ready = 0;
        chk("full_pp_count0", fifo_count, 0);

        // Reset while a write is pending
        cfg_wr = 1; cfg_prescale = 6'd32; rx_busy = 1;
        step();
        cfg_wr = 0;
        step();
        RST = 1;
        step();
        RST = 0; rx_busy = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstpend_done", cfg_done, 0);
            chk("rstpend_prescale", prescale, 8);
        end

`ifdef UART_RX_CTRL_ERR_CNT_EN
        par_err = 1;
        for (int i = 0; i < 300; i++) step();
        par_err = 0;
        chk("par_cnt_sat", par_err_cnt, 255);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("par_cnt_clr", par_err_cnt, 0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RST        = ($urandom_range(0, 299) == 0);
            cfg_wr     = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       cfg_prescale = 6'd8;
                1:       cfg_prescale = 6'd16;
                2:       cfg_prescale = 6'd32;
                default: cfg_prescale = 6'($urandom);
            endcase
            cfg_par_en  = 1'($urandom);
            cfg_par_typ = 1'($urandom);
            if ($urandom_range(0, 7) == 0) rx_busy = ~rx_busy;
            Data_Valid = ($urandom_range(0, 1) == 0);
            P_DATA     = DW'($urandom);
            par_err    = ($urandom_range(0, 4) == 0);
            stp_err    = ($urandom_range(0, 4) == 0);
            rd_ready   = ($urandom_range(0, 2) == 0);
            err_clr    = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
